// File: rtl/axi_tx_fifo_channel.sv
// rtl/axi_tx_fifo_channel.sv - transmit valid/ready channel with elastic buffer, flush and stall counter
// Head entry is held stable on VALID/xDATA until READY; all status is decoded from registered state.
module axi_tx_fifo_channel #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3,
  parameter int STALL_W   = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       tx_en,
  input  logic [WIDTH-1:0]           tx_data,
  output logic                       tx_hold,
  output logic                       VALID,
  input  logic                       READY,
  output logic [WIDTH-1:0]           xDATA,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       afull,
  output logic                       empty,
  output logic [STALL_W-1:0]         stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic             push;
  logic             pop;
  logic             hold_head;

  assign tx_hold   = (count == CNT_FULL);
  assign VALID     = (count != '0);
  assign empty     = (count == '0);
  assign afull     = (count >= CNT_AFULL);
  assign xDATA     = VALID ? mem[rd_ptr] : '0;

  // An offer in a flush cycle is dropped along with the queue.
  assign push      = tx_en & ~tx_hold & ~flush;
  assign pop       = VALID & READY;
  assign hold_head = VALID & ~READY;
  assign rd_ptr_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= rd_ptr_nxt;
      // A head already offered on the bus must stay until accepted.
      if (hold_head) begin
        wr_ptr <= rd_ptr + PTR_ONE;
        count  <= CNT_ONE;
      end else begin
        wr_ptr <= rd_ptr_nxt;
        count  <= '0;
      end
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET && push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stall_cnt <= '0;
    end else if (hold_head) begin
      if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_axi_tx_fifo_channel.sv
// tb/tb_axi_tx_fifo_channel.sv - queue-model bench for axi_tx_fifo_channel
module tb_axi_tx_fifo_channel;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int AFULL_LVL = 3;
  localparam int STALL_W   = 3;
  localparam int STALL_MAX = (1 << STALL_W) - 1;

  logic               ACLK = 1'b0;
  logic               ARESET;
  logic               tx_en;
  logic [WIDTH-1:0]   tx_data;
  logic               tx_hold;
  logic               VALID;
  logic               READY;
  logic [WIDTH-1:0]   xDATA;
  logic               flush;
  logic [2:0]         count;
  logic               afull;
  logic               empty;
  logic [STALL_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];
  int               mstall = 0;
  bit               started = 1'b0;

  bit               pv = 1'b0;
  bit               pr = 1'b0;
  bit               prst = 1'b1;
  logic [WIDTH-1:0] pd = '0;

  axi_tx_fifo_channel #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL), .STALL_W(STALL_W)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .tx_en(tx_en), .tx_data(tx_data),
    .tx_hold(tx_hold), .VALID(VALID), .READY(READY), .xDATA(xDATA),
    .flush(flush), .count(count), .afull(afull), .empty(empty),
    .stall_cnt(stall_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit v;
    bit full;
    bit pop;
    bit push;
    logic [WIDTH-1:0] head;
    if (ARESET) begin
      mq.delete();
      mstall = 0;
    end else begin
      v    = (mq.size() != 0);
      full = (mq.size() == DEPTH);
      pop  = v && READY;
      push = tx_en && !full && !flush;
      if (v && !READY) mstall = (mstall < STALL_MAX) ? mstall + 1 : mstall;
      else mstall = 0;
      if (flush) begin
        if (v && !READY) begin
          head = mq[0];
          mq.delete();
          mq.push_back(head);
        end else begin
          mq.delete();
        end
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(tx_data);
      end
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    model_step();
    #1;
  endtask

  always @(negedge ACLK) begin
    int n;
    logic [31:0] exp_d;
    if (started) begin
      n = mq.size();
      exp_d = (n != 0) ? 32'(mq[0]) : 32'd0;
      chk("VALID", VALID, n != 0);
      chk("xDATA", xDATA, exp_d);
      chk("count", count, n);
      chk("tx_hold", tx_hold, n == DEPTH);
      chk("afull", afull, n >= AFULL_LVL);
      chk("empty", empty, n == 0);
      chk("stall_cnt", stall_cnt, mstall);
      if (pv && !pr && !prst) begin
        chk("held_valid", VALID, 1);
        chk("held_data", xDATA, pd);
      end
      pv   = VALID;
      pd   = xDATA;
      pr   = READY;
      prst = ARESET;
    end
  end

  initial begin
    ARESET = 1'b1; tx_en = 1'b1; tx_data = 8'h5A; READY = 1'b1; flush = 1'b0;
    step();
    started = 1'b1;
    step();
    chk("rst_valid", VALID, 0);
    chk("rst_xdata", xDATA, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_hold", tx_hold, 0);
    chk("rst_afull", afull, 0);
    ARESET = 1'b0; tx_en = 1'b0;
    step();
    chk("idle_empty", empty, 1);

    READY = 1'b1; tx_en = 1'b1; tx_data = 8'h11;
    step();
    chk("s1_valid", VALID, 1);
    chk("s1_data", xDATA, 8'h11);
    tx_data = 8'h22;
    step();
    chk("s2_data", xDATA, 8'h22);
    chk("s2_count", count, 1);
    tx_data = 8'h33;
    step();
    chk("s3_data", xDATA, 8'h33);
    tx_en = 1'b0;
    step();
    chk("s_drained", empty, 1);

    READY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tx_en = 1'b1; tx_data = 8'(8'hA0 + i);
      step();
      if (i == 2) begin
        chk("fill_afull3", afull, 1);
        chk("fill_count3", count, 3);
      end
    end
    chk("fill_count", count, 4);
    chk("fill_hold", tx_hold, 1);
    chk("fill_head", xDATA, 8'hA0);
    chk("fill_stall", stall_cnt, 5);

    READY = 1'b1; tx_en = 1'b1; tx_data = 8'hB0;
    step();
    chk("fp_count", count, 3);
    chk("fp_head", xDATA, 8'hA1);
    step();
    chk("fp2_count", count, 3);
    chk("fp2_head", xDATA, 8'hA2);
    tx_en = 1'b0;
    step();
    chk("drain_a3", xDATA, 8'hA3);
    step();
    chk("drain_b0", xDATA, 8'hB0);
    step();
    chk("drain_empty", empty, 1);

    READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_en = 1'b1; tx_data = 8'(8'hC0 + i);
      step();
    end
    tx_en = 1'b0;
    chk("pre_flush_count", count, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_count", count, 1);
    chk("flush_head", xDATA, 8'hC0);
    chk("flush_valid", VALID, 1);
    READY = 1'b1;
    step();
    chk("flush_drain", empty, 1);

    READY = 1'b0; tx_en = 1'b1; tx_data = 8'hD0;
    step();
    tx_en = 1'b0;
    repeat (10) step();
    chk("stall_sat", stall_cnt, 7);
    chk("stall_head", xDATA, 8'hD0);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    chk("mid_rst_valid", VALID, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_stall", stall_cnt, 0);

    for (int i = 0; i < 800; i++) begin
      tx_en   = ($urandom_range(0, 3) != 0);
      tx_data = 8'($urandom);
      if (((i / 100) % 2) == 0) READY = ($urandom_range(0, 3) == 0);
      else READY = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      ARESET  = ($urandom_range(0, 79) == 0);
      step();
    end
    ARESET = 1'b0; flush = 1'b0; tx_en = 1'b0; READY = 1'b1;
    repeat (6) step();
    chk("final_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
